// File: rtl/alarm_set.sv
// Alarm time / enable setting from push-buttons, with field-by-field shadow edit and atomic commit.
// Optional hold-to-repeat on UP/DOWN is built when ALARM_SET_AUTOREPEAT_EN is defined.
module alarm_set #(
  parameter logic [16:0] DEFAULT_ALARM = 17'd25200,
  parameter int unsigned REPEAT_DELAY  = 50000,
  parameter int unsigned REPEAT_PERIOD = 10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_enable,
  output logic [16:0] alarm_time,
  output logic        alarm_enable,
  output logic        editing,
  output logic [1:0]  edit_field,
  output logic [4:0]  edit_hour,
  output logic [5:0]  edit_min,
  output logic [5:0]  edit_sec
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StEditHour = 2'd1,
    StEditMin  = 2'd2,
    StEditSec  = 2'd3
  } state_e;

  // Button bit order: 0 = mode, 1 = up, 2 = down, 3 = enable
  logic [3:0] sync1_q, sync2_q, prev_q, press;

  state_e      state_q, state_d;
  logic        enable_q, enable_d;
  logic [16:0] alarm_time_q, alarm_time_d;
  logic [4:0]  hour_q, hour_d;
  logic [5:0]  min_q, min_d;
  logic [5:0]  sec_q, sec_d;

  logic        up_step, down_step;
  logic [16:0] time_rem;
  logic [4:0]  load_hour;
  logic [5:0]  load_min, load_sec;
  logic [16:0] commit_time;
  logic [5:0]  stepped;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= {btn_enable, btn_down, btn_up, btn_mode};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign press = sync2_q & ~prev_q;

  function automatic logic [5:0] wrap_step(logic [5:0] v, logic [5:0] max, logic up);
    if (up) return (v == max) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? max : v - 6'd1;
  endfunction

`ifdef ALARM_SET_AUTOREPEAT_EN
  localparam logic [16:0] DelayC  = 17'(REPEAT_DELAY);
  localparam logic [16:0] PeriodC = 17'(REPEAT_PERIOD);

  logic [16:0] cnt_q, cnt_d;
  logic        rpt_fire, holding;

  // Counter measures cycles since the press step; after the first repeat it is rewound by
  // one period so later repeats land every REPEAT_PERIOD cycles (needs DELAY >= PERIOD).
  always_comb begin
    cnt_d    = '0;
    rpt_fire = 1'b0;
    holding  = (state_q != StIdle) && (sync2_q[1] ^ sync2_q[2]) && !press[0] && !press[3];
    if (holding && !(press[1] || press[2])) begin
      if (cnt_q + 17'd1 == DelayC) begin
        rpt_fire = 1'b1;
        cnt_d    = DelayC - PeriodC;
      end else begin
        cnt_d = cnt_q + 17'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign up_step   = (press[1] & ~press[2]) | (rpt_fire & sync2_q[1]);
  assign down_step = (press[2] & ~press[1]) | (rpt_fire & sync2_q[2]);
`else
  logic unused_cfg;
  assign unused_cfg = ^{17'(REPEAT_DELAY), 17'(REPEAT_PERIOD)};

  assign up_step   = press[1] & ~press[2];
  assign down_step = press[2] & ~press[1];
`endif

  assign time_rem    = alarm_time_q % 17'd3600;
  assign load_hour   = 5'(alarm_time_q / 17'd3600);
  assign load_min    = 6'(time_rem / 17'd60);
  assign load_sec    = 6'(alarm_time_q % 17'd60);
  assign commit_time = 17'(hour_q) * 17'd3600 + 17'(min_q) * 17'd60 + 17'(sec_q);

  always_comb begin
    state_d      = state_q;
    enable_d     = enable_q;
    alarm_time_d = alarm_time_q;
    hour_d       = hour_q;
    min_d        = min_q;
    sec_d        = sec_q;
    stepped      = '0;
    unique case (state_q)
      StIdle: begin
        if (press[0]) begin
          hour_d  = load_hour;
          min_d   = load_min;
          sec_d   = load_sec;
          state_d = StEditHour;
        end else if (press[3]) begin
          enable_d = ~enable_q;
        end
      end
      StEditHour, StEditMin, StEditSec: begin
        if (press[0]) begin
          if (state_q == StEditSec) begin
            alarm_time_d = commit_time;
            state_d      = StIdle;
          end else if (state_q == StEditHour) begin
            state_d = StEditMin;
          end else begin
            state_d = StEditSec;
          end
        end else if (press[3]) begin
          state_d = StIdle;
        end else if (up_step || down_step) begin
          if (state_q == StEditHour) begin
            stepped = wrap_step({1'b0, hour_q}, 6'd23, up_step);
            hour_d  = stepped[4:0];
          end else if (state_q == StEditMin) begin
            min_d = wrap_step(min_q, 6'd59, up_step);
          end else begin
            sec_d = wrap_step(sec_q, 6'd59, up_step);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      enable_q     <= 1'b0;
      alarm_time_q <= DEFAULT_ALARM;
      hour_q       <= '0;
      min_q        <= '0;
      sec_q        <= '0;
    end else begin
      state_q      <= state_d;
      enable_q     <= enable_d;
      alarm_time_q <= alarm_time_d;
      hour_q       <= hour_d;
      min_q        <= min_d;
      sec_q        <= sec_d;
    end
  end

  // Enable is masked during edit so the comparator cannot fire on a half-edited alarm.
  assign alarm_time   = alarm_time_q;
  assign editing      = (state_q != StIdle);
  assign alarm_enable = enable_q & ~editing;
  assign edit_field   = state_q;
  assign edit_hour    = hour_q;
  assign edit_min     = min_q;
  assign edit_sec     = sec_q;

endmodule

// File: tb/tb_alarm_set.sv
// Bench for alarm_set: directed scenarios plus random button events against an
// arithmetic model of the alarm-setting rules.
module tb_alarm_set;

  localparam int Delay  = 50;
  localparam int Period = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_enable = 1'b0;
  logic [16:0] alarm_time;
  logic        alarm_enable, editing;
  logic [1:0]  edit_field;
  logic [4:0]  edit_hour;
  logic [5:0]  edit_min, edit_sec;

  alarm_set #(
    .DEFAULT_ALARM (17'd25200),
    .REPEAT_DELAY  (Delay),
    .REPEAT_PERIOD (Period)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_mode     (btn_mode),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_enable   (btn_enable),
    .alarm_time   (alarm_time),
    .alarm_enable (alarm_enable),
    .editing      (editing),
    .edit_field   (edit_field),
    .edit_hour    (edit_hour),
    .edit_min     (edit_min),
    .edit_sec     (edit_sec)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Model: field 0 = idle, 1..3 = hour/minute/second being edited
  int m_time, m_en, m_field, m_h, m_m, m_s;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".alarm_time"}, 32'(alarm_time), m_time);
    check({tag, ".alarm_enable"}, 32'(alarm_enable), (m_en != 0 && m_field == 0) ? 1 : 0);
    check({tag, ".editing"}, 32'(editing), (m_field != 0) ? 1 : 0);
    check({tag, ".edit_field"}, 32'(edit_field), m_field);
    check({tag, ".edit_hour"}, 32'(edit_hour), m_h);
    check({tag, ".edit_min"}, 32'(edit_min), m_m);
    check({tag, ".edit_sec"}, 32'(edit_sec), m_s);
  endtask

  function automatic int wrap(int v, int modulus, int delta);
    return (v + delta + modulus) % modulus;
  endfunction

  task automatic model_apply(bit m, bit u, bit d, bit e);
    if (m_field == 0) begin
      if (m) begin
        m_h = m_time / 3600;
        m_m = (m_time % 3600) / 60;
        m_s = m_time % 60;
        m_field = 1;
      end else if (e) begin
        m_en = 1 - m_en;
      end
    end else if (m) begin
      if (m_field == 3) begin
        m_time  = m_h * 3600 + m_m * 60 + m_s;
        m_field = 0;
      end else begin
        m_field++;
      end
    end else if (e) begin
      m_field = 0;
    end else if (u != d) begin
      case (m_field)
        1: m_h = wrap(m_h, 24, u ? 1 : -1);
        2: m_m = wrap(m_m, 60, u ? 1 : -1);
        default: m_s = wrap(m_s, 60, u ? 1 : -1);
      endcase
    end
  endtask

  // Raw buttons go high before edge k; nothing may change by edge k+1, the action lands on k+2.
  task automatic press(string tag, bit m, bit u, bit d, bit e);
    @(negedge clk);
    {btn_mode, btn_up, btn_down, btn_enable} = {m, u, d, e};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all({tag, ".pre"});
    @(posedge clk);
    @(negedge clk);
    model_apply(m, u, d, e);
    check_all({tag, ".edge"});
    {btn_mode, btn_up, btn_down, btn_enable} = 4'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all({tag, ".after"});
  endtask

  task automatic do_reset(string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    m_time = 25200; m_en = 0; m_field = 0; m_h = 0; m_m = 0; m_s = 0;
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int steps;
    int hold;

    do_reset("reset");

    // Full edit: hour 7 -> 9, minute 0 -> 59, second 0 -> 5
    press("fe_mode", 1, 0, 0, 0);
    repeat (2) press("fe_up_h", 0, 1, 0, 0);
    press("fe_mode", 1, 0, 0, 0);
    press("fe_dn_m", 0, 0, 1, 0);
    press("fe_mode", 1, 0, 0, 0);
    repeat (5) press("fe_up_s", 0, 1, 0, 0);
    press("fe_commit", 1, 0, 0, 0);
    check("fe_time35945", 32'(alarm_time), 35945);

    // Wrap below zero on hour, then cancel
    do_reset("reset2");
    press("wr_mode", 1, 0, 0, 0);
    repeat (8) press("wr_dn_h", 0, 0, 1, 0);
    check("wr_hour23", 32'(edit_hour), 23);
    press("wr_cancel", 0, 0, 0, 1);
    check("wr_time_kept", 32'(alarm_time), 25200);

    // Enable gating across a full edit
    press("en_toggle", 0, 0, 0, 1);
    check("en_on", 32'(alarm_enable), 1);
    press("en_mode1", 1, 0, 0, 0);
    check("en_masked", 32'(alarm_enable), 0);
    press("en_up_h", 0, 1, 0, 0);
    press("en_mode2", 1, 0, 0, 0);
    press("en_mode3", 1, 0, 0, 0);
    press("en_commit", 1, 0, 0, 0);
    check("en_restored", 32'(alarm_enable), 1);

    // Simultaneous events
    press("si_mode", 1, 0, 0, 0);
    press("si_updown", 0, 1, 1, 0);
    press("si_mode2", 1, 0, 0, 0);
    press("si_up_m", 0, 1, 0, 0);
    press("si_mode_en", 1, 0, 0, 1);
    check("si_field_sec", 32'(edit_field), 3);
    press("si_mode_up", 1, 1, 0, 0);
    press("si_mode3", 1, 0, 0, 0);
    press("si_mode4", 1, 0, 0, 0);
    do_reset("si_reset_mid_edit");

    // Hold UP on minute 0 for 82 cycles past the press step
    press("ar_mode", 1, 0, 0, 0);
    press("ar_mode2", 1, 0, 0, 0);
    hold = 82;
    @(negedge clk);
    btn_up = 1'b1;
    repeat (3) @(posedge clk);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    btn_up = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
`ifdef ALARM_SET_AUTOREPEAT_EN
    steps = 1 + ((hold >= Delay) ? (hold - Delay) / Period + 1 : 0);
`else
    steps = 1;
`endif
    m_m = (m_m + steps) % 60;
    check_all("ar_hold");

    // Random single and combined button events
    for (int i = 0; i < 120; i++) begin
      int r;
      r = $urandom_range(0, 11);
      case (r)
        0, 1, 2:  press("rnd_mode", 1, 0, 0, 0);
        3, 4, 5:  press("rnd_up", 0, 1, 0, 0);
        6, 7, 8:  press("rnd_dn", 0, 0, 1, 0);
        9:        press("rnd_en", 0, 0, 0, 1);
        10:       press("rnd_updn", 0, 1, 1, 0);
        default:  press("rnd_combo", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
